// File: rtl/kgp_rf_pkg.sv
// Shared types and helpers for the KGP-RISC register file with scoreboard.
// Holds the clear-engine state type, default sizes and the address legality rule.
package kgp_rf_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  // A legal address names real storage: in range and not the hardwired-zero r0.
  function automatic logic addr_legal(input int unsigned addr,
                                      input int unsigned num_regs,
                                      input bit          zero_reg);
    return (addr < num_regs) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Sequenced clear engine: walks every register index once, one per cycle.
// clr_req is sampled only while idle; clr_busy is high for exactly NUM_REGS cycles.
module rf_clear_seq
  import kgp_rf_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx,
  output rf_state_t         state_o
);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          idx_d   = '0;
        end
      end
      RF_CLEAR: begin
        // The last index returns to idle without advancing past NUM_REGS-1.
        if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = RF_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = RF_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign clr_busy = (state_q == RF_CLEAR);
  assign clr_we   = (state_q == RF_CLEAR);
  assign clr_idx  = idx_q;
  assign state_o  = state_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-to-read bypass, optional zero r0,
// a per-register pending scoreboard and a sequenced clear engine.
module reg_file_sb
  import kgp_rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0] rd_data_1,
  output logic              rd_pend_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_pend_2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  rf_state_t         clr_state;
  logic              clr_active;
  logic              wr_legal, issue_legal;
  logic              hit_1, hit_2;

  // clr_req/clr_busy is a request/busy pair, not valid/ready: a request is
  // accepted on any edge where the engine is idle, and busy then stays high
  // until every index has been cleared; requests seen while busy are dropped.
  rf_clear_seq #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx),
    .state_o  (clr_state)
  );

  assign clr_active  = (clr_state == RF_CLEAR);
  assign wr_legal    = wr_en && !clr_active && addr_legal(32'(wr_addr), NUM_REGS, ZR);
  assign issue_legal = issue_en && !clr_active && addr_legal(32'(issue_addr), NUM_REGS, ZR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Issue is applied after the write so a same-address pair leaves the bit set.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (clr_we && (clr_idx == ADDR_W'(i))) begin
        regs_d[i] = '0;
        pend_d[i] = 1'b0;
      end
      if (wr_legal && (wr_addr == ADDR_W'(i))) begin
        regs_d[i] = wr_data;
        pend_d[i] = 1'b0;
      end
      if (issue_legal && (issue_addr == ADDR_W'(i))) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  assign hit_1 = BP && wr_legal && (wr_addr == rd_addr_1);
  assign hit_2 = BP && wr_legal && (wr_addr == rd_addr_2);

  always_comb begin
    rd_data_1 = '0;
    rd_pend_1 = 1'b0;
    rd_data_2 = '0;
    rd_pend_2 = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_1 == ADDR_W'(i)) begin
        rd_data_1 = regs_q[i];
        rd_pend_1 = pend_q[i];
      end
      if (rd_addr_2 == ADDR_W'(i)) begin
        rd_data_2 = regs_q[i];
        rd_pend_2 = pend_q[i];
      end
    end
    if (hit_1) begin
      rd_data_1 = wr_data;
      rd_pend_1 = 1'b0;
    end
    if (hit_2) begin
      rd_data_2 = wr_data;
      rd_pend_2 = 1'b0;
    end
    // Out-of-range and hardwired-zero addresses read as an idle zero register.
    if (!addr_legal(32'(rd_addr_1), NUM_REGS, ZR)) begin
      rd_data_1 = '0;
      rd_pend_1 = 1'b0;
    end
    if (!addr_legal(32'(rd_addr_2), NUM_REGS, ZR)) begin
      rd_data_2 = '0;
      rd_pend_2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rd_addr_1 = '0, rd_addr_2 = '0;
  logic [31:0] rd_data_1, rd_data_2;
  logic        rd_pend_1, rd_pend_2;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_addr = '0;
  logic        clr_req = 1'b0;
  logic        clr_busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit [31:0] m_regs [32];
  bit        m_pend [32];
  bit        m_busy;
  int        m_left;

  reg_file_sb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr_1  (rd_addr_1),
    .rd_data_1  (rd_data_1),
    .rd_pend_1  (rd_pend_1),
    .rd_addr_2  (rd_addr_2),
    .rd_data_2  (rd_data_2),
    .rd_pend_2  (rd_pend_2),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A clear walks r0..r31 in order; m_left counts the registers still to wipe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] <= '0;
        m_pend[i] <= 1'b0;
      end
      m_busy <= 1'b0;
      m_left <= 0;
    end else if (m_busy) begin
      m_regs[32 - m_left] <= '0;
      m_pend[32 - m_left] <= 1'b0;
      m_left <= m_left - 1;
      if (m_left == 1) m_busy <= 1'b0;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] <= wr_data;
        m_pend[wr_addr] <= 1'b0;
      end
      if (issue_en && issue_addr != 0) m_pend[issue_addr] <= 1'b1;
      if (clr_req) begin
        m_busy <= 1'b1;
        m_left <= 32;
      end
    end
  end

  function automatic bit bypass_hit(input logic [4:0] a);
    return wr_en && !m_busy && (wr_addr != 0) && (wr_addr == a);
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (bypass_hit(a)) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_pend(input logic [4:0] a);
    if (a == 0 || bypass_hit(a)) return 1'b0;
    return m_pend[a];
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_rd_data_1", rd_data_1, exp_data(rd_addr_1));
    chk("cmp_rd_pend_1", 32'(rd_pend_1), 32'(exp_pend(rd_addr_1)));
    chk("cmp_rd_data_2", rd_data_2, exp_data(rd_addr_2));
    chk("cmp_rd_pend_2", 32'(rd_pend_2), 32'(exp_pend(rd_addr_2)));
    chk("cmp_clr_busy",  32'(clr_busy),  32'(m_busy));
  end

  // ---------------- driver ----------------
  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ie, input logic [4:0] ia, input logic cr,
                        input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    wr_en = we; wr_addr = wa; wr_data = wd;
    issue_en = ie; issue_addr = ia; clr_req = cr;
    rd_addr_1 = a1; rd_addr_2 = a2;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, a1, a2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;

    // Reset state
    #12;
    chk("reset_rd_data_1", rd_data_1, 32'h0);
    chk("reset_clr_busy", 32'(clr_busy), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Write r5, bypass same cycle, stored next cycle
    set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
    #1 chk("bypass_r5", rd_data_1, 32'hDEADBEEF);
    idle(5'd5, 5'd5);
    #1 chk("stored_r5", rd_data_1, 32'hDEADBEEF);
    chk("stored_r5_p2", rd_data_2, 32'hDEADBEEF);

    // Hardwired zero r0
    set_in(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    #1 chk("r0_no_bypass", rd_data_1, 32'h0);
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    #1 chk("r0_data", rd_data_1, 32'h0);
    idle(5'd0, 5'd0);
    #1 chk("r0_pend", 32'(rd_pend_1), 32'h0);

    // Issue then writeback of r7
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
    idle(5'd7, 5'd0);
    #1 chk("r7_pend_set", 32'(rd_pend_1), 32'h1);
    set_in(1'b1, 5'd7, 32'hA5A5_0007, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
    #1 chk("r7_pend_bypass", 32'(rd_pend_1), 32'h0);
    chk("r7_data_bypass", rd_data_1, 32'hA5A5_0007);
    idle(5'd7, 5'd0);
    #1 chk("r7_pend_clear", 32'(rd_pend_1), 32'h0);

    // Same-cycle issue and write of r9: data lands, new producer keeps it pending
    set_in(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0);
    idle(5'd9, 5'd9);
    #1 chk("r9_data", rd_data_1, 32'h55);
    chk("r9_pend", 32'(rd_pend_2), 32'h1);

    // Fill r1..r31 then sequenced clear; writes/issues/requests while busy are dropped
    for (int i = 1; i < 32; i++)
      set_in(1'b1, 5'(i), 32'h0101_0101 * 32'(i), 1'b1, 5'(32 - i), 1'b0, 5'(i), 5'(32 - i));
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3, 5'd31);
    busy_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      set_in(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      #1 if (clr_busy) busy_cnt++;
    end
    idle(5'd0, 5'd0);
    chk("clear_busy_cycles", 32'(busy_cnt), 32'd32);
    #1 chk("clear_busy_low", 32'(clr_busy), 32'h0);
    for (int r = 0; r < 32; r++) begin
      rd_addr_1 = 5'(r); rd_addr_2 = 5'(r);
      #1 chk("after_clear_data", rd_data_1, 32'h0);
      chk("after_clear_pend", 32'(rd_pend_2), 32'h0);
    end

    // Reset while clearing index 10
    set_in(1'b1, 5'd20, 32'hCAFE_0020, 1'b1, 5'd20, 1'b0, 5'd0, 5'd0);
    set_in(1'b1, 5'd12, 32'hCAFE_0012, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd20, 5'd12);
    for (int k = 0; k < 11; k++) idle(5'd20, 5'd12);
    #1 chk("mid_clear_r20_pend", 32'(rd_pend_1), 32'h1);
    rst_n = 1'b0;
    #1 chk("rst_busy", 32'(clr_busy), 32'h0);
    chk("rst_r20_data", rd_data_1, 32'h0);
    chk("rst_r20_pend", 32'(rd_pend_1), 32'h0);
    chk("rst_r12_data", rd_data_2, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    set_in(1'b1, 5'd3, 32'h77, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
    #1 chk("post_rst_bypass", rd_data_1, 32'h77);
    idle(5'd3, 5'd0);
    #1 chk("post_rst_stored", rd_data_1, 32'h77);

    // Randomized traffic, checked by the per-cycle compare process
    for (int k = 0; k < 600; k++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 49) == 0),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    idle(5'd0, 5'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
